// File: rtl/int_to_float_pipelined_converter.sv
// int_to_float_pipelined_converter
//
// Pipelined integer to IEEE-754 binary converter used by the FP unit for the
// FCVT.S.W/WU/L/LU and FCVT.D.* family. It handles signed or unsigned sources
// and the five RISC-V rounding modes, and it reports the NX (inexact) flag.
// The configured widths guarantee that overflow, underflow and specials
// cannot occur.
//
// Pipeline ranks (every rank moves together when 'advance' is high):
//   operand register -> stage 1 (sign/magnitude) -> stage 2 (normalise)
//   -> stage 3 (round/pack, drives the outputs)
// An operand accepted at edge N is presented after edge N+3.
//
// Ports:
//   clock           rising-edge clock
//   reset_n         asynchronous active-low reset
//   in_valid        operand valid
//   in_ready        converter can accept an operand this cycle
//   input_integer   source integer, INT_WIDTH bits
//   sign_mode       1 = two's-complement source, 0 = unsigned source
//   rounding_mode   RISC-V rm: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
//   out_valid       result valid
//   out_ready       consumer accepts the result
//   converted_float packed {sign, exponent, mantissa}
//   inexact         result differs from the exact integer value
module int_to_float_pipelined_converter #(
  parameter int INT_WIDTH = 64,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [INT_WIDTH-1:0]           input_integer,
  input  logic                           sign_mode,
  input  logic [2:0]                     rounding_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   converted_float,
  output logic                           inexact
);

  localparam int LZC_WIDTH = $clog2(INT_WIDTH + 1);
  localparam int FLOAT_WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;
  // Normalised magnitude without its implicit one, followed by enough zero
  // fill that a guard bit and at least one sticky bit always exist.
  localparam int EXT_WIDTH = INT_WIDTH + 1 + MAN_WIDTH;
  localparam int BIAS = 2**(EXP_WIDTH-1) - 1;
  localparam logic [EXP_WIDTH-1:0] EXP_TOP = EXP_WIDTH'(INT_WIDTH - 1 + BIAS);

  logic advance;

  // Operand register
  logic                 opValid_q;
  logic [INT_WIDTH-1:0] opInt_q;
  logic                 opSignMode_q;
  logic [2:0]           opRm_q;

  // Stage 1: sign and magnitude
  logic                 s1Sign_d;
  logic [INT_WIDTH-1:0] s1Mag_d;
  logic                 s1Valid_q;
  logic                 s1Sign_q;
  logic [INT_WIDTH-1:0] s1Mag_q;
  logic [2:0]           s1Rm_q;

  // Stage 2: leading-zero count and normalisation
  logic [LZC_WIDTH-1:0] s2Lzc_d;
  logic [INT_WIDTH-1:0] s2Norm_d;
  logic                 s2Valid_q;
  logic                 s2Sign_q;
  logic [LZC_WIDTH-1:0] s2Lzc_q;
  logic [INT_WIDTH-1:0] s2Norm_q;
  logic [2:0]           s2Rm_q;

  // Stage 3: rounding and packing
  logic [EXT_WIDTH-1:0]   ext;
  logic [MAN_WIDTH-1:0]   mant;
  logic                   guardBit;
  logic                   stickyBit;
  logic                   roundUp;
  logic [MAN_WIDTH:0]     mantSum;
  logic [EXP_WIDTH-1:0]   expBiased;
  logic [FLOAT_WIDTH-1:0] outFloat_d;
  logic                   outInexact_d;
  logic                   outValid_q;
  logic [FLOAT_WIDTH-1:0] outFloat_q;
  logic                   outInexact_q;

  // A stalled output freezes every rank, so nothing can be accepted either.
  assign advance  = ~outValid_q | out_ready;
  assign in_ready = advance;

  assign out_valid       = outValid_q;
  assign converted_float = outFloat_q;
  assign inexact         = outInexact_q;

  // Two's-complement negation of the most-negative value wraps back to
  // 2^(INT_WIDTH-1), which is exactly the magnitude read as unsigned.
  always_comb begin
    s1Sign_d = opSignMode_q & opInt_q[INT_WIDTH-1];
    s1Mag_d  = s1Sign_d ? (~opInt_q + INT_WIDTH'(1)) : opInt_q;
  end

  // The highest set bit is written last, so it decides the count. A zero
  // magnitude leaves the count at INT_WIDTH and a normalised MSB of 0,
  // and stage 3 uses that MSB as its nonzero indicator.
  always_comb begin
    s2Lzc_d = LZC_WIDTH'(INT_WIDTH);
    for (int i = 0; i < INT_WIDTH; i++) begin
      if (s1Mag_q[i]) begin
        s2Lzc_d = LZC_WIDTH'(INT_WIDTH - 1 - i);
      end
    end
    s2Norm_d = s1Mag_q << s2Lzc_d;
  end

  // A carry out of the mantissa increment leaves the mantissa bits at zero,
  // so only the exponent needs the extra one.
  always_comb begin
    ext       = {s2Norm_q[INT_WIDTH-2:0], {(MAN_WIDTH + 2){1'b0}}};
    mant      = ext[EXT_WIDTH-1 -: MAN_WIDTH];
    guardBit  = ext[INT_WIDTH];
    stickyBit = |ext[INT_WIDTH-1:0];
    case (s2Rm_q)
      3'b001:  roundUp = 1'b0;
      3'b010:  roundUp = s2Sign_q & (guardBit | stickyBit);
      3'b011:  roundUp = ~s2Sign_q & (guardBit | stickyBit);
      3'b100:  roundUp = guardBit;
      default: roundUp = guardBit & (stickyBit | mant[0]);
    endcase
    mantSum   = {1'b0, mant} + (MAN_WIDTH + 1)'(roundUp);
    expBiased = EXP_TOP - EXP_WIDTH'(s2Lzc_q) + EXP_WIDTH'(mantSum[MAN_WIDTH]);
    outFloat_d   = '0;
    outInexact_d = 1'b0;
    if (s2Norm_q[INT_WIDTH-1]) begin
      outFloat_d   = {s2Sign_q, expBiased, mantSum[MAN_WIDTH-1:0]};
      outInexact_d = guardBit | stickyBit;
    end
  end

  // All ranks shift together; bubbles travel as cleared valid bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opValid_q    <= 1'b0;
      opInt_q      <= '0;
      opSignMode_q <= 1'b0;
      opRm_q       <= '0;
      s1Valid_q    <= 1'b0;
      s1Sign_q     <= 1'b0;
      s1Mag_q      <= '0;
      s1Rm_q       <= '0;
      s2Valid_q    <= 1'b0;
      s2Sign_q     <= 1'b0;
      s2Lzc_q      <= '0;
      s2Norm_q     <= '0;
      s2Rm_q       <= '0;
      outValid_q   <= 1'b0;
      outFloat_q   <= '0;
      outInexact_q <= 1'b0;
    end else if (advance) begin
      opValid_q    <= in_valid;
      opInt_q      <= input_integer;
      opSignMode_q <= sign_mode;
      opRm_q       <= rounding_mode;
      s1Valid_q    <= opValid_q;
      s1Sign_q     <= s1Sign_d;
      s1Mag_q      <= s1Mag_d;
      s1Rm_q       <= opRm_q;
      s2Valid_q    <= s1Valid_q;
      s2Sign_q     <= s1Sign_q;
      s2Lzc_q      <= s2Lzc_d;
      s2Norm_q     <= s2Norm_d;
      s2Rm_q       <= s1Rm_q;
      outValid_q   <= s2Valid_q;
      outFloat_q   <= outFloat_d;
      outInexact_q <= outInexact_d;
    end
  end

endmodule
